// File: rtl/fixed_divider.sv
// fixed_divider: iterative signed Q15.48 restoring divider with valid/ready on input and output.
// Define FIXED_DIV_RADIX4_EN to retire two quotient bits per edge (56 steps instead of 112).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// in_ready is high only in IDLE. out_valid is high only in DONE, and the outputs stay
// stable until out_ready is seen.

module fixed_divider #(
   parameter int FRAC_BITS = 48,
   parameter int WIDTH     = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int NUM_BITS = WIDTH + FRAC_BITS;
`ifdef FIXED_DIV_RADIX4_EN
   localparam int BITS_PER_STEP = 2;
`else
   localparam int BITS_PER_STEP = 1;
`endif
   localparam int STEPS = NUM_BITS / BITS_PER_STEP;
   localparam int CNT_W = $clog2(STEPS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 2);
   localparam logic [WIDTH-1:0] SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG  = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_IDLE, ST_DIVIDE, ST_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_num;
   logic [WIDTH-1:0] r_dsr;
   logic [WIDTH-1:0] r_q;
   logic             r_sticky;
   logic             r_sign;
   logic [CNT_W-1:0] r_cnt;
   logic             r_valid;
   logic [WIDTH-1:0] r_quot;
   logic             r_dbz;
   logic             r_ovf;

   // One restoring step: returns {quotient bit, next remainder}. The shifted partial
   // remainder is WIDTH+1 bits; the new remainder is always below the divisor.
   function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] rem,
                                             input logic             bit_in,
                                             input logic [WIDTH-1:0] dsr);
      logic [WIDTH:0] sh;
      logic           ge;
      sh = {rem, bit_in};
      ge = (sh >= {1'b0, dsr});
      f_step = ge ? {1'b1, sh[WIDTH-1:0] - dsr} : {1'b0, sh[WIDTH-1:0]};
   endfunction

   logic             w_idle;
   logic [WIDTH-1:0] w_abs_dvd;
   logic [WIDTH-1:0] w_abs_dsr;
   logic [WIDTH-1:0] w_rem0, w_num0, w_dsr, w_q0;
   logic             w_st0;
   logic [WIDTH:0]   w_s1;
   logic [WIDTH-1:0] w_rem1, w_num1, w_q1;
   logic             w_st1;
   logic [WIDTH-1:0] w_rem_nx, w_num_nx, w_q_nx;
   logic             w_st_nx;
   logic             w_ovf_nx;
   logic [WIDTH-1:0] w_res_nx;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
   assign w_abs_dsr = divisor[WIDTH-1]  ? -divisor  : divisor;

   // The accept edge already performs the first step straight from the input
   // magnitudes, so the accept edge counts as the first edge of the latency.
   assign w_rem0 = w_idle ? '0        : r_rem;
   assign w_num0 = w_idle ? w_abs_dvd : r_num;
   assign w_dsr  = w_idle ? w_abs_dsr : r_dsr;
   assign w_q0   = w_idle ? '0        : r_q;
   assign w_st0  = w_idle ? 1'b0      : r_sticky;

   assign w_s1   = f_step(w_rem0, w_num0[WIDTH-1], w_dsr);
   assign w_rem1 = w_s1[WIDTH-1:0];
   assign w_q1   = {w_q0[WIDTH-2:0], w_s1[WIDTH]};
   assign w_st1  = w_st0 | w_q0[WIDTH-1];
   assign w_num1 = {w_num0[WIDTH-2:0], 1'b0};

`ifdef FIXED_DIV_RADIX4_EN
   logic [WIDTH:0] w_s2;
   assign w_s2     = f_step(w_rem1, w_num1[WIDTH-1], w_dsr);
   assign w_rem_nx = w_s2[WIDTH-1:0];
   assign w_q_nx   = {w_q1[WIDTH-2:0], w_s2[WIDTH]};
   assign w_st_nx  = w_st1 | w_q1[WIDTH-1];
   assign w_num_nx = {w_num1[WIDTH-2:0], 1'b0};
`else
   assign w_rem_nx = w_rem1;
   assign w_q_nx   = w_q1;
   assign w_st_nx  = w_st1;
   assign w_num_nx = w_num1;
`endif

   // Anything with a bit at or above the sign position cannot be represented.
   assign w_ovf_nx = w_st_nx | w_q_nx[WIDTH-1];
   assign w_res_nx = w_ovf_nx ? (r_sign ? SAT_NEG : SAT_POS)
                              : (r_sign ? -w_q_nx : w_q_nx);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_rem    <= '0;
         r_num    <= '0;
         r_dsr    <= '0;
         r_q      <= '0;
         r_sticky <= 1'b0;
         r_sign   <= 1'b0;
         r_cnt    <= '0;
         r_valid  <= 1'b0;
         r_quot   <= '0;
         r_dbz    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (divisor == '0) begin
                     r_state <= ST_DONE;
                     r_valid <= 1'b1;
                     r_quot  <= dividend[WIDTH-1] ? SAT_NEG : SAT_POS;
                     r_dbz   <= 1'b1;
                     r_ovf   <= 1'b1;
                  end else begin
                     r_state  <= ST_DIVIDE;
                     r_rem    <= w_rem_nx;
                     r_num    <= w_num_nx;
                     r_dsr    <= w_abs_dsr;
                     r_q      <= w_q_nx;
                     r_sticky <= w_st_nx;
                     r_sign   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     r_cnt    <= '0;
                  end
               end
            end
            ST_DIVIDE: begin
               r_rem    <= w_rem_nx;
               r_num    <= w_num_nx;
               r_q      <= w_q_nx;
               r_sticky <= w_st_nx;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) begin
                  r_state <= ST_DONE;
                  r_valid <= 1'b1;
                  r_quot  <= w_res_nx;
                  r_dbz   <= 1'b0;
                  r_ovf   <= w_ovf_nx;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready    = w_idle;
   assign out_valid   = r_valid;
   assign quotient    = r_quot;
   assign div_by_zero = r_dbz;
   assign overflow    = r_ovf;

endmodule
